// File: rtl/timer_bank_pkg.sv
// Shared constants for the timer bank: channel state encoding, default widths
// and the channel run-state transition rule.
package timer_bank_pkg;

  localparam int unsigned TIMER_BITWIDTH_DEF     = 32;
  localparam int unsigned NB_CAPTURES_DEF        = 10;
  localparam int unsigned PRESCALER_BITWIDTH_DEF = 8;

  typedef enum logic [1:0] {
    TIMER_STOPPED = 2'b00,
    TIMER_RUNNING = 2'b01,
    TIMER_PAUSED  = 2'b10
  } timer_state_e;

  // Enable-driven transition; clear handling is done by the caller.
  function automatic timer_state_e timer_next_state(timer_state_e cur, logic en);
    timer_state_e nxt;
    nxt = cur;
    case (cur)
      TIMER_STOPPED: nxt = en ? TIMER_RUNNING : TIMER_STOPPED;
      TIMER_RUNNING: nxt = en ? TIMER_RUNNING : TIMER_PAUSED;
      TIMER_PAUSED:  nxt = en ? TIMER_RUNNING : TIMER_PAUSED;
      default:       nxt = TIMER_STOPPED;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: run-state machine plus loadable counter advanced by the
// shared tick, with a one-cycle wrap pulse.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int unsigned TIMER_BITWIDTH = TIMER_BITWIDTH_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_an_i,
  input  logic                      rst_i,
  input  logic                      tick_i,
  input  logic                      en_i,
  input  logic                      clr_i,
  input  logic                      load_i,
  input  logic [TIMER_BITWIDTH-1:0] load_value_i,
  output logic [TIMER_BITWIDTH-1:0] counter_o,
  output logic                      wrap_o,
  output logic                      running_o
);

  timer_state_e state_q;
  timer_state_e state_d;

  assign state_d = clr_i ? TIMER_STOPPED : timer_next_state(state_q, en_i);

  // Priority: soft clear > channel clear > load > increment.
  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      state_q   <= TIMER_STOPPED;
      counter_o <= '0;
      wrap_o    <= 1'b0;
      running_o <= 1'b0;
    end else if (rst_i) begin
      state_q   <= TIMER_STOPPED;
      counter_o <= '0;
      wrap_o    <= 1'b0;
      running_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_o <= (state_d == TIMER_RUNNING);
      wrap_o    <= 1'b0;
      if (clr_i) begin
        counter_o <= '0;
      end else if (load_i) begin
        counter_o <= load_value_i;
      end else if ((state_q == TIMER_RUNNING) && tick_i) begin
        counter_o <= counter_o + TIMER_BITWIDTH'(1);
        wrap_o    <= &counter_o;
      end
    end
  end

endmodule

// File: rtl/timer_bank.sv
// Bank of independent timer channels sharing one prescaler that produces the
// count tick every prescale_i+1 enabled cycles.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int unsigned TIMER_BITWIDTH     = TIMER_BITWIDTH_DEF,
  parameter int unsigned NB_CAPTURES        = NB_CAPTURES_DEF,
  parameter int unsigned PRESCALER_BITWIDTH = PRESCALER_BITWIDTH_DEF
) (
  input  logic                                  clk_i,
  input  logic                                  rst_an_i,
  input  logic                                  rst_i,
  input  logic [PRESCALER_BITWIDTH-1:0]         prescale_i,
  input  logic [NB_CAPTURES-1:0]                timer_en_i,
  input  logic [NB_CAPTURES-1:0]                timer_clr_i,
  input  logic [NB_CAPTURES-1:0]                load_i,
  input  logic [TIMER_BITWIDTH*NB_CAPTURES-1:0] load_value_i,
  output logic [TIMER_BITWIDTH*NB_CAPTURES-1:0] counter_o,
  output logic [NB_CAPTURES-1:0]                wrap_o,
  output logic [NB_CAPTURES-1:0]                running_o
);

  logic [PRESCALER_BITWIDTH-1:0] presc_q;
  logic                          any_en_c;
  logic                          tick_c;

  assign any_en_c = |timer_en_i;
  // >= compare so a lowered divisor ticks at once instead of waiting for a wrap.
  assign tick_c   = any_en_c && (presc_q >= prescale_i);

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      presc_q <= '0;
    end else if (rst_i || !any_en_c || tick_c) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PRESCALER_BITWIDTH'(1);
    end
  end

  for (genvar i = 0; i < NB_CAPTURES; i++) begin : g_ch
    timer_channel #(
      .TIMER_BITWIDTH(TIMER_BITWIDTH)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_an_i    (rst_an_i),
      .rst_i       (rst_i),
      .tick_i      (tick_c),
      .en_i        (timer_en_i[i]),
      .clr_i       (timer_clr_i[i]),
      .load_i      (load_i[i]),
      .load_value_i(load_value_i[i*TIMER_BITWIDTH +: TIMER_BITWIDTH]),
      .counter_o   (counter_o[i*TIMER_BITWIDTH +: TIMER_BITWIDTH]),
      .wrap_o      (wrap_o[i]),
      .running_o   (running_o[i])
    );
  end

endmodule

// File: tb/tb_timer_bank.sv
// Bench for timer_bank: directed scenarios plus randomized traffic, all checked
// every cycle against a behavioural model of the bank.
module tb_timer_bank;

  localparam int TW = 32;
  localparam int NC = 10;
  localparam int PW = 8;

  logic                 clk_i = 1'b0;
  logic                 rst_an_i;
  logic                 rst_i;
  logic [PW-1:0]        prescale_i;
  logic [NC-1:0]        timer_en_i;
  logic [NC-1:0]        timer_clr_i;
  logic [NC-1:0]        load_i;
  logic [TW*NC-1:0]     load_value_i;
  logic [TW*NC-1:0]     counter_o;
  logic [NC-1:0]        wrap_o;
  logic [NC-1:0]        running_o;

  timer_bank #(
    .TIMER_BITWIDTH    (TW),
    .NB_CAPTURES       (NC),
    .PRESCALER_BITWIDTH(PW)
  ) dut (
    .clk_i       (clk_i),
    .rst_an_i    (rst_an_i),
    .rst_i       (rst_i),
    .prescale_i  (prescale_i),
    .timer_en_i  (timer_en_i),
    .timer_clr_i (timer_clr_i),
    .load_i      (load_i),
    .load_value_i(load_value_i),
    .counter_o   (counter_o),
    .wrap_o      (wrap_o),
    .running_o   (running_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: cycles since last tick, and per-channel count/run/wrap.
  logic [TW-1:0] m_cnt [NC];
  bit            m_run [NC];
  bit            m_wrap[NC];
  int            m_pre;

  task automatic model_zero();
    m_pre = 0;
    for (int i = 0; i < NC; i++) begin
      m_cnt[i]  = '0;
      m_run[i]  = 1'b0;
      m_wrap[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit any;
    bit tick;
    bit was_run;
    if (!rst_an_i || rst_i) begin
      model_zero();
      return;
    end
    any  = |timer_en_i;
    tick = any && (m_pre >= int'(prescale_i));
    m_pre = (any && !tick) ? m_pre + 1 : 0;
    for (int i = 0; i < NC; i++) begin
      was_run   = m_run[i];
      m_wrap[i] = 1'b0;
      if (timer_clr_i[i]) begin
        m_cnt[i] = '0;
        m_run[i] = 1'b0;
      end else begin
        m_run[i] = timer_en_i[i];
        if (load_i[i]) begin
          m_cnt[i] = load_value_i[i*TW +: TW];
        end else if (was_run && tick) begin
          m_wrap[i] = (m_cnt[i] == {TW{1'b1}});
          m_cnt[i]  = m_cnt[i] + 1;
        end
      end
    end
  endtask

  function automatic logic [TW*NC-1:0] m_cnt_vec();
    logic [TW*NC-1:0] v;
    for (int i = 0; i < NC; i++) v[i*TW +: TW] = m_cnt[i];
    return v;
  endfunction

  function automatic logic [NC-1:0] m_wrap_vec();
    logic [NC-1:0] v;
    for (int i = 0; i < NC; i++) v[i] = m_wrap[i];
    return v;
  endfunction

  function automatic logic [NC-1:0] m_run_vec();
    logic [NC-1:0] v;
    for (int i = 0; i < NC; i++) v[i] = m_run[i];
    return v;
  endfunction

  function automatic logic [TW-1:0] ch(input int i);
    return counter_o[i*TW +: TW];
  endfunction

  task automatic check_w(input string tag, input logic [TW*NC-1:0] obs, input logic [TW*NC-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_s(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply current inputs across one rising edge, then compare with the model.
  task automatic cycle();
    model_step();
    @(posedge clk_i);
    #1;
    check_w("counter", counter_o, m_cnt_vec());
    check_s("wrap", 32'(wrap_o), 32'(m_wrap_vec()));
    check_s("running", 32'(running_o), 32'(m_run_vec()));
  endtask

  task automatic soft_clear();
    timer_en_i  = '0;
    timer_clr_i = '0;
    load_i      = '0;
    rst_i       = 1'b1;
    cycle();
    rst_i       = 1'b0;
  endtask

  initial begin
    rst_an_i     = 1'b0;
    rst_i        = 1'b0;
    prescale_i   = 8'd3;
    timer_en_i   = '0;
    timer_clr_i  = '0;
    load_i       = '0;
    load_value_i = '0;
    model_zero();
    #7;
    check_w("reset_counter", counter_o, '0);
    check_s("reset_wrap", 32'(wrap_o), 32'd0);
    check_s("reset_running", 32'(running_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_an_i = 1'b1;

    // Divide-by-4 from reset: counts 1,2,3 after 4,8,12 edges; running after 1.
    timer_en_i[0] = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      cycle();
      if (j == 1)  check_s("t032_running", 32'(running_o[0]), 32'd1);
      if (j == 3)  check_s("t032_cnt0", ch(0), 32'd0);
      if (j == 4)  check_s("t032_cnt1", ch(0), 32'd1);
      if (j == 8)  check_s("t032_cnt2", ch(0), 32'd2);
      if (j == 12) check_s("t032_cnt3", ch(0), 32'd3);
    end
    soft_clear();

    // Wrap from all-ones on channel 1.
    prescale_i = 8'd0;
    load_value_i[1*TW +: TW] = 32'hFFFF_FFFE;
    load_i[1] = 1'b1;
    cycle();
    check_s("t033_load", ch(1), 32'hFFFF_FFFE);
    check_s("t033_load_nowrap", 32'(wrap_o), 32'd0);
    load_i[1] = 1'b0;
    timer_en_i[1] = 1'b1;
    cycle();
    cycle();
    check_s("t033_ones", ch(1), 32'hFFFF_FFFF);
    cycle();
    check_s("t033_zero", ch(1), 32'd0);
    check_s("t033_wrap", 32'(wrap_o), 32'h2);
    cycle();
    check_s("t033_wrap_gone", 32'(wrap_o), 32'd0);
    check_s("t033_after", ch(1), 32'd1);
    soft_clear();

    // Clear beats load on channel 2.
    load_value_i[2*TW +: TW] = 32'd6;
    load_i[2] = 1'b1;
    timer_en_i[2] = 1'b1;
    cycle();
    load_i[2] = 1'b0;
    cycle();
    check_s("t034_at7", ch(2), 32'd7);
    load_value_i[2*TW +: TW] = 32'd100;
    load_i[2] = 1'b1;
    timer_clr_i[2] = 1'b1;
    cycle();
    check_s("t034_cleared", ch(2), 32'd0);
    check_s("t034_stopped", 32'(running_o[2]), 32'd0);
    check_s("t034_nowrap", 32'(wrap_o), 32'd0);
    load_i[2] = 1'b0;
    timer_clr_i[2] = 1'b0;
    cycle();
    check_s("t034_rerun", 32'(running_o[2]), 32'd1);
    soft_clear();

    // Pause channel 3 for three ticks while channel 4 keeps counting.
    load_value_i[3*TW +: TW] = 32'd4;
    load_i[3] = 1'b1;
    timer_en_i[3] = 1'b1;
    timer_en_i[4] = 1'b1;
    cycle();
    load_i[3] = 1'b0;
    timer_en_i[3] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      cycle();
      check_s("t035_hold5", ch(3), 32'd5);
    end
    check_s("t035_paused", 32'(running_o[3]), 32'd0);
    check_s("t035_ch4", ch(4), 32'd3);
    timer_en_i[3] = 1'b1;
    cycle();
    check_s("t035_resume_hold", ch(3), 32'd5);
    cycle();
    check_s("t035_resume6", ch(3), 32'd6);
    check_s("t035_ch4b", ch(4), 32'd5);
    soft_clear();

    // Asynchronous reset mid-count, divide-by-3.
    prescale_i = 8'd2;
    timer_en_i[0] = 1'b1;
    for (int j = 0; j < 5; j++) cycle();
    #2;
    rst_an_i = 1'b0;
    #1;
    model_zero();
    check_w("t036_async_counter", counter_o, '0);
    check_s("t036_async_running", 32'(running_o), 32'd0);
    check_s("t036_async_wrap", 32'(wrap_o), 32'd0);
    cycle();
    rst_an_i = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      cycle();
      if (j < 3) check_s("t036_pre", ch(0), 32'd0);
      else       check_s("t036_first", ch(0), 32'd1);
    end
    soft_clear();

    // Divisor lowered below the current prescaler count.
    prescale_i = 8'd200;
    timer_en_i[5] = 1'b1;
    for (int j = 0; j < 50; j++) cycle();
    check_s("t037_before", ch(5), 32'd0);
    prescale_i = 8'd10;
    cycle();
    check_s("t037_immediate", ch(5), 32'd1);
    for (int j = 0; j < 10; j++) cycle();
    check_s("t037_hold", ch(5), 32'd1);
    cycle();
    check_s("t037_period", ch(5), 32'd2);
    soft_clear();

    // Randomized traffic against the model.
    for (int j = 0; j < 400; j++) begin
      prescale_i  = PW'($urandom_range(0, 4));
      timer_en_i  = NC'($urandom | $urandom);
      timer_clr_i = NC'($urandom & $urandom & $urandom & $urandom);
      load_i      = NC'($urandom & $urandom & $urandom);
      for (int i = 0; i < NC; i++) begin
        if ($urandom_range(0, 2) == 0)
          load_value_i[i*TW +: TW] = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        else
          load_value_i[i*TW +: TW] = 32'($urandom);
      end
      rst_i = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
